// File: rtl/mips_pkg.sv
// mips_pkg -- definitions shared by the HI/LO multiply unit and its users.
// Contents: ALU operation codes (only ALU_mul starts a multiply), read-select
// codes for mfhi/mflo, and the multiply FSM state enum.
// No ports; import with "import mips_pkg::*;".
package mips_pkg;

    // ALU operation codes as seen on the op port.
    localparam logic [2:0] ALU_add = 3'b000;
    localparam logic [2:0] ALU_sub = 3'b001;
    localparam logic [2:0] ALU_and = 3'b010;
    localparam logic [2:0] ALU_or  = 3'b011;
    localparam logic [2:0] ALU_mul = 3'b100;

    // Read-select codes for the dout mux.
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_HI   = 2'b01;
    localparam logic [1:0] SEL_LO   = 2'b10;

    // Multiply sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mult_state_e;

endpackage

// File: rtl/mult_hilo_unit_if.sv
// mult_hilo_unit_if -- request/read bus of the HI/LO multiply unit.
// Parameter WIDTH: operand width; hi and lo are WIDTH bits each.
// Signals: start/op/mad/sgn/a/b/sel (core -> unit),
//          busy/done/hi/lo/dout (unit -> core).
// Modports: master = the issuing core, slave = mult_hilo_unit.
interface mult_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic             mad;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, op, mad, sgn, a, b, sel,
        input  busy, done, hi, lo, dout
    );

    modport slave (
        input  start, op, mad, sgn, a, b, sel,
        output busy, done, hi, lo, dout
    );
endinterface

// File: rtl/shift_add_core.sv
// shift_add_core -- radix-2 shift-add multiply datapath.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : latch operands, clear partial product and counter
//   step       : perform one shift-add iteration
//   signed_op  : treat a/b as two's complement (sampled on load)
//   a, b       : multiplicand / multiplier (WIDTH bits)
//   product    : result including the current iteration (valid when last=1)
//   last       : counter is at WIDTH-1, i.e. this step is the final one
// Signed operands are converted to magnitudes on load and the result is
// negated at the end when the operand signs differ, so latency is unchanged.
module shift_add_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] pp_r;
    logic [CW-1:0]      cnt_r;
    logic               neg_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [2*WIDTH-1:0] sum_s;

    // Operand magnitudes for the load cycle.
    always_comb begin
        a_neg_s = signed_op & a[WIDTH-1];
        b_neg_s = signed_op & b[WIDTH-1];
        if (a_neg_s) begin
            mag_a_s = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_a_s = a;
        end
        if (b_neg_s) begin
            mag_b_s = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_b_s = b;
        end
    end

    // One iteration: add the shifted multiplicand when the multiplier LSB is set;
    // the final product is taken from this sum so it lands on the last step edge.
    always_comb begin
        if (mplier_r[0]) begin
            sum_s = pp_r + mcand_r;
        end else begin
            sum_s = pp_r;
        end
        if (neg_r) begin
            product = ~sum_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            product = sum_s;
        end
        last = (cnt_r == CW'(WIDTH - 1));
    end

    // Datapath registers: load, iterate, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            pp_r     <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_r    <= 1'b0;
        end else if (load) begin
            mcand_r  <= {{WIDTH{1'b0}}, mag_a_s};
            mplier_r <= mag_b_s;
            pp_r     <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_r    <= a_neg_s ^ b_neg_s;
        end else if (step) begin
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            pp_r     <= sum_s;
            cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            neg_r    <= neg_r;
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            pp_r     <= pp_r;
            cnt_r    <= cnt_r;
            neg_r    <= neg_r;
        end
    end

endmodule

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit -- multi-cycle multiply unit owning the HI/LO registers.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mult_hilo_unit_if.slave (start/op/mad/sgn/a/b/sel in,
//          busy/done/hi/lo/dout out)
// A start with op=ALU_mul in IDLE runs WIDTH shift-add steps in CALC; the
// last step writes {hi,lo} (replace or accumulate), then DONE pulses done.
// Configuration macro: MULT_SIGNED_EN -- when defined, sgn=1 selects a
// two's complement multiply; otherwise sgn is ignored (unsigned only).
module mult_hilo_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    mult_hilo_unit_if.slave bus
);
    mult_state_e        state_r;
    mult_state_e        state_s;
    logic               load_s;
    logic               step_s;
    logic               wr_s;
    logic               mad_r;
    logic               signed_op_s;
    logic [2*WIDTH-1:0] hilo_r;
    logic [2*WIDTH-1:0] product_s;
    logic               last_s;
    logic [WIDTH-1:0]   dout_s;

`ifdef MULT_SIGNED_EN
    assign signed_op_s = bus.sgn;
`else
    assign signed_op_s = 1'b0;
`endif

    shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .signed_op (signed_op_s),
        .a         (bus.a),
        .b         (bus.b),
        .product   (product_s),
        .last      (last_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        wr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start && (bus.op == ALU_mul)) begin
                    state_s = CALC;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_s = DONE;
                    wr_s    = 1'b1;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Accumulate flag is captured with the operands so mid-operation changes
    // on the bus cannot alter the write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mad_r <= 1'b0;
        end else if (load_s) begin
            mad_r <= bus.mad;
        end else begin
            mad_r <= mad_r;
        end
    end

    // HI/LO register: written only on the final CALC step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hilo_r <= {(2*WIDTH){1'b0}};
        end else if (wr_s) begin
            if (mad_r) begin
                hilo_r <= hilo_r + product_s;
            end else begin
                hilo_r <= product_s;
            end
        end else begin
            hilo_r <= hilo_r;
        end
    end

    // mfhi/mflo read mux; reflects the current (pre-operation) HI/LO during CALC.
    always_comb begin
        case (bus.sel)
            SEL_HI:  dout_s = hilo_r[2*WIDTH-1:WIDTH];
            SEL_LO:  dout_s = hilo_r[WIDTH-1:0];
            default: dout_s = {WIDTH{1'b0}};
        endcase
    end

    assign bus.busy = (state_r == CALC);
    assign bus.done = (state_r == DONE);
    assign bus.hi   = hilo_r[2*WIDTH-1:WIDTH];
    assign bus.lo   = hilo_r[WIDTH-1:0];
    assign bus.dout = dout_s;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb_mult_hilo_unit -- self-checking bench for mult_hilo_unit (WIDTH=32).
// A timeline model (phase 0 = idle, 1..32 = busy, 33 = done) with 64-bit
// arithmetic results is compared against the DUT on every falling edge;
// directed literal checks pin the model, then random operations follow.
module tb_mult_hilo_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_hilo_unit_if #(.WIDTH(W)) bus ();

    mult_hilo_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    // Reference state.
    logic [63:0] m_hilo  = 64'h0;
    logic [63:0] m_res   = 64'h0;
    int          m_phase = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                                 input logic mad, input logic sgn,
                                                 input logic [63:0] old);
        logic [63:0] p;
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {32'h0, a};
        eb = {32'h0, b};
`ifdef MULT_SIGNED_EN
        if (sgn) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end
`endif
        p = ea * eb;   // low 64 bits of the sign-extended product are exact
        if (sgn && 1'b0) p = 64'h0;
        return mad ? (old + p) : p;
    endfunction

    // Timeline model.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_hilo  <= 64'h0;
        end else if (m_phase == 0) begin
            if (bus.start && bus.op == 3'b100) begin
                m_phase <= 1;
                m_res   <= model_result(bus.a, bus.b, bus.mad, bus.sgn, m_hilo);
            end
        end else if (m_phase < 32) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == 32) begin
            m_phase <= 33;
            m_hilo  <= m_res;
        end else begin
            m_phase <= 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [31:0] exp_dout;
        case (bus.sel)
            2'b01:   exp_dout = m_hilo[63:32];
            2'b10:   exp_dout = m_hilo[31:0];
            default: exp_dout = 32'h0;
        endcase
        check("busy", {63'h0, bus.busy}, {63'h0, (m_phase >= 1 && m_phase <= 32)});
        check("done", {63'h0, bus.done}, {63'h0, (m_phase == 33)});
        check("hi", {32'h0, bus.hi}, {32'h0, m_hilo[63:32]});
        check("lo", {32'h0, bus.lo}, {32'h0, m_hilo[31:0]});
        check("dout", {32'h0, bus.dout}, {32'h0, exp_dout});
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
    end

    // Issue one multiply; optionally re-pulse start at cycle inject, or reset at cycle abort.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic mad,
                           input logic sgn, input int inject, input int abort);
        bit finished = 1'b0;
        @(posedge clk); #2;
        busy_cnt = 0;
        done_cnt = 0;
        bus.start = 1'b1; bus.op = 3'b100;
        bus.a = a; bus.b = b; bus.mad = mad; bus.sgn = sgn;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #2;
            bus.start = 1'b0;
            bus.sel = 2'($urandom_range(0, 3));
            bus.a = $urandom; bus.b = $urandom;
            bus.mad = 1'($urandom); bus.sgn = 1'($urandom);
            if (n == inject) bus.start = 1'b1;
            if (n == abort) begin
                rst = 1'b1;
                #1;
                check("abort_busy", {63'h0, bus.busy}, 64'h0);
                check("abort_done", {63'h0, bus.done}, 64'h0);
                check("abort_hilo", {bus.hi, bus.lo}, 64'h0);
                @(posedge clk); #2;
                rst = 1'b0;
                finished = 1'b1;
                break;
            end
            if (n > 0 && m_phase == 0) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check("timeout", 64'h0, 64'h1);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'b000; bus.mad = 1'b0; bus.sgn = 1'b0;
        bus.a = 32'h0; bus.b = 32'h0; bus.sel = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", {63'h0, bus.busy}, 64'h0);
        check("rst_done", {63'h0, bus.done}, 64'h0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        rst = 1'b0;

        // Non-multiply op in IDLE is ignored.
        @(posedge clk); #2;
        done_cnt = 0;
        bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd7; bus.b = 32'd9;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("op010_busy", {63'h0, bus.busy}, 64'h0);
        check("op010_done", 64'(done_cnt), 64'd0);

        // 3*5 with a second start injected mid-CALC.
        run_mul(32'd3, 32'd5, 1'b0, 1'b0, 10, -1);
        check("busy_cycles", 64'(busy_cnt), 64'd32);
        check("one_done", 64'(done_cnt), 64'd1);
        check("mul3x5", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);

        run_mul(32'd2, 32'd4, 1'b1, 1'b0, -1, -1);
        check("mad_2x4", {bus.hi, bus.lo}, 64'h0000_0000_0000_0017);

        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, -1);
        check("max_sq", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        bus.sel = 2'b01; #1; check("dout_hi", {32'h0, bus.dout}, 64'h0000_0000_FFFF_FFFE);
        bus.sel = 2'b10; #1; check("dout_lo", {32'h0, bus.dout}, 64'h0000_0000_0000_0001);
        bus.sel = 2'b11; #1; check("dout_none", {32'h0, bus.dout}, 64'h0);

        run_mul(32'hFFFF_FFFE, 32'd1, 1'b1, 1'b0, -1, -1);
        run_mul(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, -1, -1);
        check("all_ones", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_mul(32'd1, 32'd1, 1'b1, 1'b0, -1, -1);
        check("wrap", {bus.hi, bus.lo}, 64'h0);

        // Reset at cycle 16 of CALC.
        run_mul(32'd12345, 32'd678, 1'b0, 1'b0, -1, 16);
        repeat (3) @(posedge clk);
        #2;
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_hilo_after", {bus.hi, bus.lo}, 64'h0);

        run_mul(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, -1, -1);
`ifdef MULT_SIGNED_EN
        check("sgn_neg1x2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        check("sgn_neg1x2", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
`endif

        for (int i = 0; i < 20; i++) begin
            run_mul($urandom, $urandom, 1'($urandom), 1'($urandom), -1, -1);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
